// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the MEM stage: datapath widths, the
// timeout default and the MEM-stage controller state encoding.
// Optional timeout feature in the users of this package: MEM_TIMEOUT_EN.
package cpu_pkg;

    localparam int DATA_W          = 64;
    localparam int WN_W            = 5;
    localparam int TIMEOUT_CYC_DEF = 16;

    // IDLE: no access outstanding. WAIT: request issued, waiting for dm_ack.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller
// (master) and the data memory (slave).
//
// Handshake: the master raises dm_req together with dm_we, dm_addr and
// dm_wdata, and holds all four stable until the slave returns a one-cycle
// dm_ack pulse. dm_rdata is valid only in the dm_ack cycle. dm_ack may
// arrive in the first dm_req cycle; dm_ack seen while dm_req=0 is ignored.
interface mem_stage_ctrl_if
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DATA_W
);

    logic          dm_req;
    logic          dm_we;
    logic [DW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );

endinterface

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write-back controls and
// holds the data fields; load data is captured only when rdata_we_i is set.
module mem_wb_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int WN_W   = cpu_pkg::WN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble_i,
    input  logic              rw_i,
    input  logic              m2r_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [WN_W-1:0]   wn_i,
    input  logic              rdata_we_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              wb_rw_o,
    output logic              wb_m2r_o,
    output logic [DATA_W-1:0] wb_result_o,
    output logic [WN_W-1:0]   wb_wn_o,
    output logic [DATA_W-1:0] wb_rdata_o
);

    logic              rw_q;
    logic              m2r_q;
    logic [DATA_W-1:0] result_q;
    logic [WN_W-1:0]   wn_q;
    logic [DATA_W-1:0] rdata_q;

    // Pipeline register: bubble or load each cycle, load data on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q     <= 1'b0;
            m2r_q    <= 1'b0;
            result_q <= '0;
            wn_q     <= '0;
            rdata_q  <= '0;
        end else begin
            if (bubble_i) begin
                rw_q  <= 1'b0;
                m2r_q <= 1'b0;
            end else begin
                rw_q     <= rw_i;
                m2r_q    <= m2r_i;
                result_q <= result_i;
                wn_q     <= wn_i;
            end
            if (rdata_we_i) begin
                rdata_q <= rdata_i;
            end
        end
    end

    assign wb_rw_o     = rw_q;
    assign wb_m2r_o    = m2r_q;
    assign wb_result_o = result_q;
    assign wb_wn_o     = wn_q;
    assign wb_rdata_o  = rdata_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory requests for loads/stores,
// stalls the front of the pipeline while an access is outstanding,
// resolves branches and drives the MEM/WB register.
// Optional feature macro: MEM_TIMEOUT_EN (bounded WAIT with sticky mem_err).
module mem_stage_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W      = cpu_pkg::DATA_W,
    parameter int WN_W        = cpu_pkg::WN_W,
    parameter int TIMEOUT_CYC = cpu_pkg::TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_pc,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] mem_rd2,
    input  logic [WN_W-1:0]   mem_wn,
    input  logic              mem_rw,
    input  logic              mem_m2r,
    input  logic              mem_mr,
    input  logic              mem_mw,
    input  logic              mem_branch,
    input  logic              mem_zero,
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    mem_stage_ctrl_if.master  dm,
    output logic              wb_rw,
    output logic              wb_m2r,
    output logic [DATA_W-1:0] wb_rdata,
    output logic [DATA_W-1:0] wb_result,
    output logic [WN_W-1:0]   wb_wn,
    output logic              mem_err,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bubble;
    logic              rdata_we;
    logic              mem_op;
    logic              timeout_hit;

    assign mem_op = mem_mr | mem_mw;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // cnt_q counts WAIT cycles already spent without ack; the TIMEOUT_CYC-th
    // WAIT cycle is the terminal one, so the abort lands right after it.
    assign timeout_hit = (state_q == WAIT) && !dm.dm_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign mem_err     = err_q;

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    logic [31:0] timeout_cyc_unused;

    assign timeout_cyc_unused = 32'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
    assign mem_err            = 1'b0;
`endif

    // FSM state and the registered data-memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state, request fields and MEM/WB control for this cycle.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        bubble   = 1'b0;
        rdata_we = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    // Load and store together is treated as a store.
                    state_d = WAIT;
                    req_d   = 1'b1;
                    we_d    = mem_mw;
                    addr_d  = mem_result;
                    wdata_d = mem_rd2;
                    bubble  = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (dm.dm_ack) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    rdata_we = !we_q;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    bubble  = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end else begin
                    bubble = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d  = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall drops in the ack (or abort) cycle so EX/MEM advances on that edge.
    assign stall = rst_n & (((state_q == IDLE) & mem_op) |
                            ((state_q == WAIT) & ~dm.dm_ack & ~timeout_hit));

    assign pc_src        = rst_n & mem_branch & mem_zero & ~stall;
    assign branch_target = rst_n ? mem_pc : '0;

    assign dm.dm_req   = req_q;
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wdata = wdata_q;
    assign dbg_state   = state_q;

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .WN_W   (WN_W)
    ) u_mem_wb_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .bubble_i    (bubble),
        .rw_i        (mem_rw),
        .m2r_i       (mem_m2r),
        .result_i    (mem_result),
        .wn_i        (mem_wn),
        .rdata_we_i  (rdata_we),
        .rdata_i     (dm.dm_rdata),
        .wb_rw_o     (wb_rw),
        .wb_m2r_o    (wb_m2r),
        .wb_result_o (wb_result),
        .wb_wn_o     (wb_wn),
        .wb_rdata_o  (wb_rdata)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: table of MEM-stage ops, a write-back
// scoreboard, hand-written reset/idle-ack/timeout sequences.
module tb_mem_stage_ctrl;
    import cpu_pkg::*;

    localparam int DW   = 64;
    localparam int WW   = 5;
    localparam int WB_W = 2 + DW + WW + DW;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] mem_pc, mem_result, mem_rd2;
    logic [WW-1:0] mem_wn;
    logic          mem_rw, mem_m2r, mem_mr, mem_mw, mem_branch, mem_zero;
    logic          stall, pc_src;
    logic [DW-1:0] branch_target;
    logic          wb_rw, wb_m2r;
    logic [DW-1:0] wb_rdata, wb_result;
    logic [WW-1:0] wb_wn;
    logic          mem_err;
    state_t        dbg_state;

    mem_stage_ctrl_if #(.DW(DW)) dm_bus ();

    mem_stage_ctrl #(
        .DATA_W      (DW),
        .WN_W        (WW),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_pc        (mem_pc),
        .mem_result    (mem_result),
        .mem_rd2       (mem_rd2),
        .mem_wn        (mem_wn),
        .mem_rw        (mem_rw),
        .mem_m2r       (mem_m2r),
        .mem_mr        (mem_mr),
        .mem_mw        (mem_mw),
        .mem_branch    (mem_branch),
        .mem_zero      (mem_zero),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .dm            (dm_bus),
        .wb_rw         (wb_rw),
        .wb_m2r        (wb_m2r),
        .wb_rdata      (wb_rdata),
        .wb_result     (wb_result),
        .wb_wn         (wb_wn),
        .mem_err       (mem_err),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [WB_W-1:0] exp_q[$];
    logic [DW-1:0]   model_rdata;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every non-bubble write-back must match the oldest expected record.
    always @(posedge clk) begin
        #1;
        if (rst_n && (wb_rw || wb_m2r)) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 160'({wb_rw, wb_m2r, wb_result, wb_wn, wb_rdata}), 160'(0));
            end else begin
                check("wb_record", 160'({wb_rw, wb_m2r, wb_result, wb_wn, wb_rdata}),
                      160'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus records ----------------
    typedef struct {
        logic          rw, m2r, mr, mw, br, zero;
        logic [DW-1:0] pc, result, rd2, rdata;
        logic [WW-1:0] wn;
        int            ack_at;
        logic          exp_pc_src;
        int            exp_stall;
    } vec_t;

    function automatic vec_t mk(input logic rw, m2r, mr, mw, br, zero,
                                input logic [DW-1:0] pc, result, rd2, rdata,
                                input logic [WW-1:0] wn, input int ack_at,
                                input logic exp_pc_src, input int exp_stall);
        vec_t v;
        v.rw = rw; v.m2r = m2r; v.mr = mr; v.mw = mw; v.br = br; v.zero = zero;
        v.pc = pc; v.result = result; v.rd2 = rd2; v.rdata = rdata; v.wn = wn;
        v.ack_at = ack_at; v.exp_pc_src = exp_pc_src; v.exp_stall = exp_stall;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        mem_pc = '0; mem_result = '0; mem_rd2 = '0; mem_wn = '0;
        mem_rw = 1'b0; mem_m2r = 1'b0; mem_mr = 1'b0; mem_mw = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0;
        dm_bus.dm_ack = 1'b0;
    endtask

    // Entered and left at posedge+1; the memory answers after ack_at request cycles.
    task automatic run_vec(input vec_t v);
        logic mem_op;
        int   stalls;
        mem_op = v.mr | v.mw;
        stalls = 0;
        mem_pc = v.pc; mem_result = v.result; mem_rd2 = v.rd2; mem_wn = v.wn;
        mem_rw = v.rw; mem_m2r = v.m2r; mem_mr = v.mr; mem_mw = v.mw;
        mem_branch = v.br; mem_zero = v.zero;
        dm_bus.dm_ack = 1'b0;
        if (v.rw || v.m2r) begin
            exp_q.push_back({v.rw, v.m2r, v.result, v.wn,
                             (mem_op && !v.mw) ? v.rdata : model_rdata});
        end
        if (mem_op && !v.mw) model_rdata = v.rdata;
        #1;
        check("pc_src", 160'(pc_src), 160'(v.exp_pc_src));
        check("branch_target", 160'(branch_target), 160'(v.pc));
        if (stall) stalls++;
        @(posedge clk); #1;
        if (mem_op) begin
            for (int k = 1; k <= v.ack_at; k++) begin
                check("dm_req", 160'(dm_bus.dm_req), 160'(1));
                check("dm_we", 160'(dm_bus.dm_we), 160'(v.mw));
                check("dm_addr", 160'(dm_bus.dm_addr), 160'(v.result));
                check("dm_wdata", 160'(dm_bus.dm_wdata), 160'(v.rd2));
                check("wb_bubble", 160'({wb_rw, wb_m2r}), 160'(0));
                if (k == v.ack_at) begin
                    dm_bus.dm_ack   = 1'b1;
                    dm_bus.dm_rdata = v.rdata;
                end
                #1;
                if (stall) stalls++;
                @(posedge clk); #1;
                dm_bus.dm_ack   = 1'b0;
                dm_bus.dm_rdata = {$urandom, $urandom};
            end
            check("dm_req_drop", 160'(dm_bus.dm_req), 160'(0));
            check("state_idle", 160'(dbg_state), 160'(IDLE));
            check("wb_rdata_after", 160'(wb_rdata), 160'(model_rdata));
        end
        check("stall_cycles", 160'(stalls), 160'(v.exp_stall));
    endtask

    // ---------------- test ----------------
    vec_t tbl[8];
    vec_t rv;

    initial begin
        model_rdata = '0;
        dm_bus.dm_rdata = '0;
        drive_idle();
        rst_n = 1'b0;

        tbl[0] = mk(1,0,0,0,0,0, 64'h0, 64'h2A, 64'h0, 64'h0, 5'd3, 0, 1'b0, 0);
        tbl[1] = mk(1,1,1,0,0,0, 64'h0, 64'h100, 64'h0, 64'hDEADBEEF, 5'd7, 3, 1'b0, 3);
        tbl[2] = mk(0,0,0,1,0,0, 64'h0, 64'h80, 64'h55, 64'h0, 5'd0, 1, 1'b0, 1);
        tbl[3] = mk(0,0,0,0,1,1, 64'h400, 64'h0, 64'h0, 64'h0, 5'd0, 0, 1'b1, 0);
        tbl[4] = mk(0,0,0,0,1,0, 64'h400, 64'h0, 64'h0, 64'h0, 5'd0, 0, 1'b0, 0);
        tbl[5] = mk(0,0,1,1,0,0, 64'h0, 64'h88, 64'hA5A5, 64'hBAD, 5'd0, 2, 1'b0, 2);
        tbl[6] = mk(1,1,1,0,0,0, 64'h0, 64'h108, 64'h0, 64'h1234, 5'd9, 1, 1'b0, 1);
        tbl[7] = mk(1,0,0,0,0,0, 64'h0, {64{1'b1}}, 64'h0, 64'h0, 5'd31, 0, 1'b0, 0);

        // Reset values.
        #1;
        check("rst_outputs", 160'({stall, pc_src, dm_bus.dm_req, dm_bus.dm_we, wb_rw, wb_m2r, mem_err}), 160'(0));
        check("rst_data", 160'({wb_result, wb_wn}), 160'(0));
        check("rst_state", 160'(dbg_state), 160'(IDLE));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven ops.
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // dm_ack while no request is outstanding is ignored.
        drive_idle();
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = 64'hFFFF_0000;
        @(posedge clk); #1;
        dm_bus.dm_ack = 1'b0;
        check("idle_ack_state", 160'(dbg_state), 160'(IDLE));
        check("idle_ack_req", 160'(dm_bus.dm_req), 160'(0));
        check("idle_ack_rdata", 160'(wb_rdata), 160'(model_rdata));

        // Random mix of ALU ops, loads and stores.
        for (int i = 0; i < 10; i++) begin
            int kind;
            int ack;
            kind = $urandom_range(0, 2);
            ack  = $urandom_range(1, 4);
            case (kind)
                0: rv = mk(1,0,0,0,0,0, 64'h0, {$urandom,$urandom}, 64'h0, 64'h0, 5'($urandom_range(0,31)), 0, 1'b0, 0);
                1: rv = mk(1,1,1,0,0,0, 64'h0, {$urandom,$urandom}, 64'h0, {$urandom,$urandom}, 5'($urandom_range(0,31)), ack, 1'b0, ack);
                default: rv = mk(0,0,0,1,0,0, 64'h0, {$urandom,$urandom}, {$urandom,$urandom}, 64'h0, 5'd0, ack, 1'b0, ack);
            endcase
            run_vec(rv);
        end

        // Reset in the middle of a WAIT abandons the access.
        drive_idle();
        mem_mr = 1'b1; mem_m2r = 1'b1; mem_rw = 1'b1; mem_result = 64'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midwait_req", 160'(dm_bus.dm_req), 160'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midwait_rst_req", 160'(dm_bus.dm_req), 160'(0));
        check("midwait_rst_stall", 160'(stall), 160'(0));
        check("midwait_rst_wb", 160'({wb_rw, wb_m2r, wb_result, wb_wn, wb_rdata}), 160'(0));
        check("midwait_rst_err", 160'(mem_err), 160'(0));
        model_rdata = '0;
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midwait_state", 160'(dbg_state), 160'(IDLE));
        check("midwait_req_after", 160'(dm_bus.dm_req), 160'(0));

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after four WAIT cycles, error stays set afterwards.
        mem_mr = 1'b1; mem_m2r = 1'b1; mem_rw = 1'b1; mem_result = 64'h300;
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            check("to_req", 160'(dm_bus.dm_req), 160'(1));
            #1;
            check("to_stall", 160'(stall), 160'(k < 4));
            if (k == 4) drive_idle();
            @(posedge clk); #1;
        end
        check("to_req_drop", 160'(dm_bus.dm_req), 160'(0));
        check("to_err", 160'(mem_err), 160'(1));
        check("to_wb_bubble", 160'({wb_rw, wb_m2r}), 160'(0));
        check("to_state", 160'(dbg_state), 160'(IDLE));
        run_vec(mk(1,1,1,0,0,0, 64'h0, 64'h308, 64'h0, 64'hC0FFEE, 5'd4, 4, 1'b0, 4));
        check("to_err_sticky", 160'(mem_err), 160'(1));
`else
        check("err_tied", 160'(mem_err), 160'(0));
`endif

        // Drain and report.
        drive_idle();
        repeat (3) @(posedge clk);
        #2;
        check("sb_drain", 160'(exp_q.size()), 160'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller on the consumer side of the EX/MEM pipeline register. It reads the MEM-stage bundle, runs the data-memory request/acknowledge handshake, stalls the pipeline while an access is outstanding, and resolves branches.
- It owns the MEM/WB pipeline register and drives the write-back stage.
- The data memory has variable latency, so every load and store is a multi-cycle handshake.

Parameters:
- DATA_W, 64, datapath width (result, store data, load data, address).
- WN_W, 5, destination register number width.
- TIMEOUT_CYC, 16, maximum WAIT cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_pc  in  DATA_W  branch target computed in EX.
- mem_result  in  DATA_W  ALU result; data-memory address for loads/stores.
- mem_rd2  in  DATA_W  store data.
- mem_wn  in  WN_W  destination register.
- mem_rw, mem_m2r, mem_mr, mem_mw, mem_branch, mem_zero  in  1 each  MEM-stage control bits.
- stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- pc_src  out  1  take branch.
- branch_target  out  DATA_W  equals mem_pc.
- dm_req  out  1  data-memory request.
- dm_we  out  1  1 = store.
- dm_addr  out  DATA_W  request address.
- dm_wdata  out  DATA_W  store data.
- dm_ack  in  1  one-cycle completion pulse.
- dm_rdata  in  DATA_W  load data; valid with dm_ack.
- wb_rw, wb_m2r  out  1 each  registered WB control.
- wb_rdata, wb_result  out  DATA_W  registered load data / ALU result.
- wb_wn  out  WN_W  registered destination register.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0. Taking effect mid-access drops dm_req immediately, abandons the access, and does not set mem_err.
- FSM states: IDLE, WAIT.
- IDLE, mem_mr|mem_mw=1 (both 1 treated as store):
  - Next edge: WAIT. Register dm_req=1, dm_we=mem_mw, dm_addr=mem_result, dm_wdata=mem_rd2.
  - MEM/WB receives a bubble (wb_rw=0, wb_m2r=0; data fields hold).
- IDLE, no memory op: MEM/WB loads mem_rw, mem_m2r, mem_result, mem_wn in 1 cycle; wb_rdata holds.
- WAIT:
  - dm_req, dm_we, dm_addr and dm_wdata stay stable until ack.
  - On dm_ack=1: next edge goes to IDLE, clears dm_req and loads MEM/WB. wb_rdata=dm_rdata for loads; for stores wb_rdata holds.
  - Without ack: MEM/WB gets a bubble each cycle.
- stall (combinational) = (IDLE & (mem_mr|mem_mw)) | (WAIT & ~dm_ack). Deasserts in the ack cycle so EX/MEM advances on that same edge.
- dm_ack is ignored while dm_req=0.
- Back-to-back memory ops: the following op is seen in IDLE the cycle after ack. Minimum of 2 cycles per access (issue + ack); ack arriving in the first dm_req cycle is legal.
- pc_src (combinational) = mem_branch & mem_zero & ~stall; branch_target = mem_pc.
- A branch combined with a memory op is illegal and not checked.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-min WAIT counter (width $clog2(TIMEOUT_CYC+1)) clears on WAIT entry.
  - When the counter reaches TIMEOUT_CYC with no ack: drop dm_req, set mem_err=1 (sticky until reset), write a WB bubble, go to IDLE. stall deasserts that cycle and the instruction is discarded.
  - An ack arriving in the terminal cycle wins over the timeout.
- Undefined: WAIT is unbounded; mem_err is tied 0; no counter.

Decomposition:
- Shared package cpu_pkg: DATA_W and WN_W constants, state enum {IDLE, WAIT}.
- One natural sub-module: mem_wb_reg, the MEM/WB register with async active-low reset and bubble input. The FSM stays in mem_stage_ctrl.

Test Plan:
- Reset mid-WAIT: drop rst_n while dm_req=1 → dm_req, stall, wb_* = 0 immediately; state IDLE after release.
- ALU op (mem_rw=1, mem_result=0x2A, mem_wn=3) → stall=0; next edge wb_rw=1, wb_result=0x2A, wb_wn=3.
- Load (mem_mr=1, addr 0x100); dm_ack on the 3rd request cycle with dm_rdata=0xDEADBEEF → stall high 3 cycles; dm_addr stable; WB bubbles until wb_rdata=0xDEADBEEF, wb_m2r=1 after the ack edge.
- Store (mem_mw=1, addr 0x80, rd2=0x55); immediate ack → dm_we=1, dm_wdata=0x55; stall 1 cycle; wb_rw=0.
- Branch: mem_branch=1, mem_zero=1, mem_pc=0x400 → pc_src=1, branch_target=0x400. With mem_zero=0 → pc_src=0.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack → after 4 WAIT cycles dm_req=0, mem_err=1, stall=0; mem_err persists across a later good access.
